// File: rtl/minrv32_mem_pkg.sv
// minrv32_mem_pkg: shared types and constants for the minrv32 SRAM bridge.
package minrv32_mem_pkg;
    localparam int WAIT_W         = 3;
    localparam int MEM_WORD_BYTES = 4;
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_CAPTURE, S_DONE} state_e;
endpackage

// File: rtl/minrv32_addr_decode.sv
// minrv32_addr_decode: range check and word-address translation for a byte address.
module minrv32_addr_decode
    import minrv32_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 14,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic [31:0]           addr_i,
    output logic                  in_range_o,
    output logic [ADDR_WIDTH-1:0] word_addr_o
);
    logic [31:0] off;
    logic [31:0] word;
    assign off  = addr_i - BASE_ADDR;
    assign word = off / 32'(MEM_WORD_BYTES);
    // The explicit >= guard stops addresses below the base from wrapping into range.
    assign in_range_o  = (addr_i >= BASE_ADDR) && ((word >> ADDR_WIDTH) == 32'd0);
    assign word_addr_o = word[ADDR_WIDTH-1:0];
endmodule

// File: rtl/minrv32_sram_bridge.sv
// minrv32_sram_bridge: minrv32 mem_valid/mem_ready bus to 1-cycle-latency sync SRAM,
// with programmable wait states and out-of-range error reporting.
module minrv32_sram_bridge
    import minrv32_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 14,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  mem_valid,
    input  logic                  mem_instr,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,
    output logic                  sram_ce,
    output logic [3:0]            sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata,
    output logic                  err
);
    state_e                  state_q;
    logic [WAIT_W-1:0]       cnt_q;
    logic [31:0]             wdata_q;
    logic [3:0]              wstrb_q;
    logic [ADDR_WIDTH-1:0]   waddr_q;
    logic                    in_range_q;
    logic                    ready_q;
    logic                    err_q;
    logic [31:0]             rdata_q;
    logic                    in_range;
    logic [ADDR_WIDTH-1:0]   waddr;
    logic                    acc;
    logic                    unused_instr;

    assign unused_instr = mem_instr;

    minrv32_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(BASE_ADDR)) u_dec (
        .addr_i     (mem_addr),
        .in_range_o (in_range),
        .word_addr_o(waddr)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            waddr_q    <= '0;
            in_range_q <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (mem_valid) begin
                    wdata_q    <= mem_wdata;
                    wstrb_q    <= mem_wstrb;
                    waddr_q    <= waddr;
                    in_range_q <= in_range;
                    cnt_q      <= WAIT_W'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
                    state_q    <= WAIT_STATES > 0 ? S_WAIT : S_ACCESS;
                end
                S_WAIT: begin
                    cnt_q   <= cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
                    state_q <= cnt_q == '0 ? S_ACCESS : S_WAIT;
                end
                S_ACCESS: state_q <= S_CAPTURE;
                S_CAPTURE: begin
                    rdata_q <= (in_range_q && wstrb_q == 4'b0) ? sram_rdata : 32'h0;
                    ready_q <= 1'b1;
                    err_q   <= !in_range_q;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Out-of-range requests still walk through ACCESS but never touch the SRAM.
    assign acc        = state_q == S_ACCESS && in_range_q;
    assign sram_ce    = acc;
    assign sram_we    = acc ? wstrb_q : 4'b0;
    assign sram_addr  = acc ? waddr_q : '0;
    assign sram_wdata = acc ? wdata_q : 32'h0;
    assign mem_ready  = ready_q;
    assign mem_rdata  = rdata_q;
    assign err        = err_q;
endmodule

// File: tb/tb_minrv32_sram_bridge.sv
// tb_minrv32_sram_bridge: scoreboard bench for two bridge configurations
// (WS=0/base 0/14-bit and WS=3/base 0x1000_0000/10-bit) with behavioural SRAMs.
module tb_minrv32_sram_bridge;
    typedef struct {int d; int cyc; logic [31:0] rdata; logic err;} rexp_t;
    typedef struct {int d; int cyc; logic [13:0] addr; logic [3:0] we; logic [31:0] wdata;} aexp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid [2];
    logic        mem_instr [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [3:0]  mem_wstrb [2];
    logic        mem_ready [2];
    logic [31:0] mem_rdata [2];
    logic        sram_ce [2];
    logic [3:0]  sram_we [2];
    logic [31:0] sram_wdata [2];
    logic [31:0] sram_rdata [2];
    logic        err [2];
    logic [13:0] sa0;
    logic [9:0]  sa1;
    logic [31:0] m0 [16384];
    logic [31:0] m1 [1024];
    logic        loaded = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    rexp_t       rq [$];
    aexp_t       aq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    minrv32_sram_bridge #(.ADDR_WIDTH(14), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) u0 (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid[0]), .mem_instr(mem_instr[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]),
        .mem_ready(mem_ready[0]), .mem_rdata(mem_rdata[0]), .sram_ce(sram_ce[0]),
        .sram_we(sram_we[0]), .sram_addr(sa0), .sram_wdata(sram_wdata[0]),
        .sram_rdata(sram_rdata[0]), .err(err[0]));

    minrv32_sram_bridge #(.ADDR_WIDTH(10), .BASE_ADDR(32'h1000_0000), .WAIT_STATES(3)) u1 (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid[1]), .mem_instr(mem_instr[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]),
        .mem_ready(mem_ready[1]), .mem_rdata(mem_rdata[1]), .sram_ce(sram_ce[1]),
        .sram_we(sram_we[1]), .sram_addr(sa1), .sram_wdata(sram_wdata[1]),
        .sram_rdata(sram_rdata[1]), .err(err[1]));

    // Behavioural SRAMs: preloaded once, byte-enabled writes, 1-cycle read latency.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 16384; i++) m0[i] <= (i == 5) ? 32'hDEAD_BEEF : (32'hA5A5_0000 | i);
            for (int i = 0; i < 1024; i++) m1[i] <= (i == 8) ? 32'h1234_5678 : (32'h5A5A_0000 | i);
            loaded <= 1'b1;
        end else begin
            if (sram_ce[0]) begin
                for (int b = 0; b < 4; b++) if (sram_we[0][b]) m0[sa0][8*b+:8] <= sram_wdata[0][8*b+:8];
                sram_rdata[0] <= m0[sa0];
            end
            if (sram_ce[1]) begin
                for (int b = 0; b < 4; b++) if (sram_we[1][b]) m1[sa1][8*b+:8] <= sram_wdata[1][8*b+:8];
                sram_rdata[1] <= m1[sa1];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever a DUT shows mem_ready or sram_ce.
    always @(negedge clk) begin
        rexp_t r;
        aexp_t x;
        if (resetn) begin
            for (int d = 0; d < 2; d++) begin
                if (mem_ready[d]) begin
                    if (rq.size() == 0 || rq[0].d != d) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ready: dut%0d at cycle %0d, none expected", d, cyc);
                    end else begin
                        r = rq.pop_front();
                        chk("ready_cycle", cyc, r.cyc);
                        chk("rdata", mem_rdata[d], r.rdata);
                        chk("err", {31'b0, err[d]}, {31'b0, r.err});
                    end
                end
                if (sram_ce[d]) begin
                    if (aq.size() == 0 || aq[0].d != d) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_sram_ce: dut%0d at cycle %0d, none expected", d, cyc);
                    end else begin
                        x = aq.pop_front();
                        chk("ce_cycle", cyc, x.cyc);
                        chk("sram_addr", d ? {22'b0, sa1} : {18'b0, sa0}, {18'b0, x.addr});
                        chk("sram_we", {28'b0, sram_we[d]}, {28'b0, x.we});
                        chk("sram_wdata", sram_wdata[d], x.wdata);
                    end
                end
            end
        end
    end

    // One transaction; b2b means issued at the negedge of the previous ready cycle.
    // Request fields are scrambled after acceptance to prove the latched copy is used.
    task automatic req(input int d, input bit b2b, input bit keep, input bit drop,
                       input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input logic [31:0] er, input logic ee, input logic [13:0] wa);
        int n;
        int k;
        int w;
        w = d ? 3 : 0;
        if (!b2b) @(negedge clk);
        n = b2b ? cyc + 1 : cyc;
        mem_valid[d] = 1'b1;
        mem_addr[d]  = a;
        mem_wdata[d] = wd;
        mem_wstrb[d] = ws;
        if (!ee) aq.push_back('{d, n + 1 + w, wa, ws, wd});
        rq.push_back('{d, n + 3 + w, er, ee});
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (cyc == n + 1) begin
                mem_addr[d]  = ~a;
                mem_wdata[d] = ~wd;
                mem_wstrb[d] = ~ws;
                if (drop) mem_valid[d] = 1'b0;
            end
        end while (!mem_ready[d] && k < 20);
        if (!mem_ready[d]) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: dut%0d addr %h got no mem_ready, expected one", d, a);
        end
        if (!keep) mem_valid[d] = 1'b0;
    endtask

    task automatic chk_idle_outputs();
        for (int d = 0; d < 2; d++) begin
            chk("idle_ready", {31'b0, mem_ready[d]}, 32'h0);
            chk("idle_rdata", mem_rdata[d], 32'h0);
            chk("idle_err", {31'b0, err[d]}, 32'h0);
            chk("idle_ce", {31'b0, sram_ce[d]}, 32'h0);
            chk("idle_we", {28'b0, sram_we[d]}, 32'h0);
        end
    endtask

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            mem_valid[d] = 1'b0;
            mem_instr[d] = 1'b0;
            mem_addr[d]  = 32'h0;
            mem_wdata[d] = 32'h0;
            mem_wstrb[d] = 4'h0;
        end
        repeat (3) @(negedge clk);
        chk_idle_outputs();
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        req(0, 0, 0, 0, 32'h0000_0014, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 14'd5);
        req(0, 0, 0, 0, 32'h0000_0018, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 14'd6);
        req(0, 0, 0, 0, 32'h0000_0018, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 14'd6);
        req(0, 0, 1, 0, 32'h0000_0014, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 14'd5);
        req(0, 1, 1, 0, 32'h0000_001C, 32'h0, 4'h0, 32'hA5A5_0007, 1'b0, 14'd7);
        req(0, 1, 0, 0, 32'h0000_0018, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 14'd6);
        req(0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1, 14'd0);
        req(0, 0, 0, 0, 32'h0000_FFFC, 32'h0, 4'h0, 32'hA5A5_3FFF, 1'b0, 14'h3FFF);
        req(0, 0, 0, 0, 32'h0001_0000, 32'h7777_7777, 4'hF, 32'h0, 1'b1, 14'd0);

        req(1, 0, 0, 0, 32'h1000_0020, 32'h0000_AB00, 4'b0010, 32'h0, 1'b0, 14'd8);
        req(1, 0, 0, 0, 32'h1000_0020, 32'h0, 4'h0, 32'h1234_AB78, 1'b0, 14'd8);
        req(1, 0, 0, 0, 32'h1000_1000, 32'h5555_5555, 4'hF, 32'h0, 1'b1, 14'd0);
        req(1, 0, 0, 0, 32'h0FFF_FFFC, 32'h6666_6666, 4'hF, 32'h0, 1'b1, 14'd0);
        req(1, 0, 0, 0, 32'h1000_0FFC, 32'h0, 4'h0, 32'h5A5A_03FF, 1'b0, 14'h3FF);
        req(1, 0, 0, 1, 32'h1000_0004, 32'h0, 4'h0, 32'h5A5A_0001, 1'b0, 14'd1);
        req(1, 0, 0, 0, 32'h0000_0000, 32'h0, 4'h0, 32'h0, 1'b1, 14'd0);

        // Reset during ACCESS of a write: strobes drop at once and the write is lost.
        @(negedge clk);
        n = cyc;
        mem_valid[0] = 1'b1;
        mem_addr[0]  = 32'h0000_0018;
        mem_wdata[0] = 32'h1111_2222;
        mem_wstrb[0] = 4'hF;
        aq.push_back('{0, n + 1, 14'd6, 4'hF, 32'h1111_2222});
        @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("rst_async_we", {28'b0, sram_we[0]}, 32'h0);
        chk("rst_async_ce", {31'b0, sram_ce[0]}, 32'h0);
        mem_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        chk_idle_outputs();
        repeat (4) @(negedge clk);
        req(0, 0, 0, 0, 32'h0000_0018, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 14'd6);

        repeat (5) @(negedge clk);
        chk("ready_queue_drained", rq.size(), 32'h0);
        chk("access_queue_drained", aq.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1);
    end
endmodule

// File: doc/minrv32_sram_bridge.md
# minrv32_sram_bridge

Memory-side bridge for the minrv32 core: consumes the core's native `mem_valid`/`mem_ready` bus and drives a synchronous single-port SRAM with 1-cycle read latency. Adds a programmable number of wait states, range-checks every access, and returns a one-cycle `mem_ready` pulse per transaction. It sits directly downstream of the core's memory port.

## Interface
Parameters:
- `ADDR_WIDTH`, 14: SRAM word-address bits; capacity is `4 * 2**ADDR_WIDTH` bytes.
- `BASE_ADDR`, 32'h0000_0000: byte address of SRAM word 0; must be 4-byte aligned.
- `WAIT_STATES`, 0: extra stall cycles per access, legal range 0..7.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `mem_valid`  in  1  core request valid; held until `mem_ready`.
- `mem_instr`  in  1  instruction fetch flag; unused by the datapath.
- `mem_addr`  in  32  byte address; bits [1:0] ignored.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte write enables; 0 means read.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  32  read data, valid while `mem_ready` is high.
- `sram_ce`  out  1  SRAM access enable.
- `sram_we`  out  4  SRAM byte write enables.
- `sram_addr`  out  ADDR_WIDTH  SRAM word address.
- `sram_wdata`  out  32  SRAM write data.
- `sram_rdata`  in  32  SRAM read data, valid the cycle after a `sram_ce` read.
- `err`  out  1  pulse coincident with `mem_ready` for out-of-range accesses.

## Operation
- States: IDLE, WAIT, ACCESS, CAPTURE, DONE.
- IDLE, `mem_valid`=1:
  - Latch `mem_addr`, `mem_wdata`, `mem_wstrb`, and the range-check result.
  - Go to WAIT if `WAIT_STATES`>0, loading the counter with `WAIT_STATES-1`. Otherwise go to ACCESS.
- WAIT: decrement the counter. At 0, go to ACCESS.
- ACCESS:
  - In range: `sram_ce`=1, `sram_we`=latched wstrb, `sram_addr`=(addr-BASE_ADDR)>>2, `sram_wdata`=latched wdata.
  - Out of range: `sram_ce`=0, `sram_we`=0.
  - Next state: CAPTURE.
- CAPTURE:
  - Register `mem_rdata` as follows: `sram_rdata` for an in-range read; 32'h0 for a write or an out-of-range access.
  - Set `mem_ready` (registered). Set `err` for an out-of-range access.
  - Next state: DONE.
- DONE: `mem_ready`=1 for exactly this cycle, then go to IDLE. `mem_valid` is not sampled in DONE; the core still holds the old request in this cycle.
- Range check:
  - In range iff `mem_addr >= BASE_ADDR` and `(mem_addr - BASE_ADDR) >> 2 < 2**ADDR_WIDTH`.
  - The subtraction is unsigned 32-bit; underflow counts as out of range.
  - `mem_addr` = 32'hFFFF_FFFC with a large SRAM must not wrap into range.
- Out-of-range write: dropped entirely; no SRAM write enable is ever asserted.
- Request changes after IDLE acceptance are ignored; the latched copy is used.
- `mem_valid` dropping mid-transaction (protocol violation): the transaction still completes and `mem_ready` still pulses.
- `sram_*` outputs are combinational from state plus latched request; they are 0 outside ACCESS.
- Reset:
  - All registers clear: state IDLE, `mem_ready`=0, `mem_rdata`=0, `err`=0, counter 0.
  - `sram_ce` and `sram_we` drop immediately with `resetn` low.
  - A reset asserted mid-transaction abandons it; no `mem_ready` is issued.

## Timing
- `mem_valid` first seen high in IDLE at cycle N: `mem_ready` is high in cycle N+3+WAIT_STATES, for reads and writes alike.
- `sram_ce` is high in cycle N+1+WAIT_STATES.
- Back-to-back: the next request is sampled no earlier than cycle N+4+WAIT_STATES, so throughput is one access per 4+WAIT_STATES cycles.
- `mem_ready`, `mem_rdata`, and `err` are driven from flops; there is no combinational path from `mem_*` inputs to `mem_ready`.

## Structure
- Package `minrv32_mem_pkg` holds the state enum type, `WAIT_W`=3, and the `MEM_WORD_BYTES`=4 constant.
- Sub-module `minrv32_addr_decode` (combinational) computes `in_range` and the word address from `mem_addr`, `BASE_ADDR`, and `ADDR_WIDTH`.

## Test plan
- Read, `WAIT_STATES`=0: preload word 5 with 32'hDEAD_BEEF, request `mem_addr`=32'h14 at cycle 10 -> `sram_ce` at cycle 11 with `sram_addr`=5; `mem_ready`=1 and `mem_rdata`=32'hDEAD_BEEF at cycle 13; `err`=0.
- Byte write, `WAIT_STATES`=3: write 32'h0000_AB00 to 32'h20 with wstrb 4'b0010 at cycle 0 -> `sram_we`=4'b0010 at cycle 4, `mem_ready` at cycle 6. A following read of 32'h20 returns only byte 1 changed.
- Out of range, `BASE_ADDR`=32'h1000_0000, `ADDR_WIDTH`=10: write to 32'h1000_1000, then to 32'h0FFF_FFFC -> `sram_ce` never high; each gets a `mem_ready` pulse with `err`=1 and `mem_rdata`=0.
- Back-to-back: `mem_valid` held high across 3 reads -> exactly 3 `mem_ready` pulses spaced 4 cycles apart, no duplicate SRAM access.
- Reset mid-operation: `resetn` low during ACCESS of a write -> `sram_we` drops in the same cycle; after release, all outputs are 0 and the next request completes normally.
- Protocol violation: `mem_valid` dropped in WAIT -> `mem_ready` still pulses once with the latched address's data.
